// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 7-segment scan: debounce, decode and rebuild a 4-digit score.
// Optional: define SEG_SCAN_BLANK_EN to accept an all-off hundreds/thousands digit as a leading-blank zero.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        sampleClk,
    input  logic        rst,
    input  logic [3:0]  whichseg,
    input  logic [6:0]  segval,
    output logic [13:0] score,
    output logic        scoreValid,
    output logic        frameErr,
    output logic        stale,
    output logic [3:0]  digitMask
);

    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(STABLE_CYCLES);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] IDLE_HIT = TW'(TIMEOUT_CYCLES - 1);

    logic [10:0]      sample_q;
    logic [RW-1:0]    run_q, run_d;
    logic [TW-1:0]    idle_q, idle_d;
    logic [3:0][3:0]  dig_q, dig_d;
    logic [3:0]       mask_q, mask_d, err_q, err_d;
    logic             done_q, done_d;
    logic [13:0]      score_q, score_d;
    logic             valid_q, valid_d, ferr_q, ferr_d, stale_q, stale_d;

    logic [10:0]      newSample;
    logic             changed, slotLegal, capture, timeoutHit;
    logic [1:0]       slotIdx;
    logic [4:0]       decoded;
    logic [3:0]       maskBase, errBase;

    // Returns {illegal, digit} for an active-low segment pattern in the given slot.
    function automatic logic [4:0] decodeSeg(input logic [6:0] seg, input logic [1:0] slot);
        logic [4:0] res;
        res = 5'b1_0000;
        case (seg)
            7'b0000001: res = 5'd0;
            7'b1001111: res = 5'd1;
            7'b0010010: res = 5'd2;
            7'b0000110: res = 5'd3;
            7'b1001100: res = 5'd4;
            7'b0100100: res = 5'd5;
            7'b0100000: res = 5'd6;
            7'b0001111: res = 5'd7;
            7'b0000000: res = 5'd8;
            7'b0000100: res = 5'd9;
`ifdef SEG_SCAN_BLANK_EN
            7'b1111111: res = (slot[1]) ? 5'd0 : 5'b1_0000;
`else
            7'b1111111: res = (slot == slot) ? 5'b1_0000 : 5'b1_0000;
`endif
            default:    res = 5'b1_0000;
        endcase
        return res;
    endfunction

    always_comb begin
        newSample = {whichseg, segval};
        changed   = (newSample != sample_q);
        slotLegal = 1'b1;
        slotIdx   = 2'd0;
        case (whichseg)
            4'b0111: slotIdx = 2'd0;
            4'b1011: slotIdx = 2'd1;
            4'b1101: slotIdx = 2'd2;
            4'b1110: slotIdx = 2'd3;
            default: slotLegal = 1'b0;
        endcase

        if (changed)
            run_d = RW'(1);
        else if (run_q == RUN_MAX)
            run_d = run_q;
        else
            run_d = run_q + RW'(1);

        // A restart that lands straight on the threshold still counts as reaching it.
        capture    = slotLegal && (run_d == RUN_MAX) && (changed || run_q != RUN_MAX);
        decoded    = decodeSeg(segval, slotIdx);

        timeoutHit = !capture && (idle_q == IDLE_HIT);
        if (capture)
            idle_d = '0;
        else if (idle_q == IDLE_MAX)
            idle_d = idle_q;
        else
            idle_d = idle_q + TW'(1);

        stale_d = capture ? 1'b0 : (timeoutHit ? 1'b1 : stale_q);

        valid_d = done_q;
        ferr_d  = done_q && (|err_q);
        score_d = score_q;
        if (done_q && !(|err_q))
            score_d = 14'(dig_q[3]) * 14'd1000 + 14'(dig_q[2]) * 14'd100
                    + 14'(dig_q[1]) * 14'd10 + 14'(dig_q[0]);

        // Frame clears happen first so a capture on the same edge opens the next frame.
        maskBase = (done_q || timeoutHit) ? 4'b0000 : mask_q;
        errBase  = (done_q || timeoutHit) ? 4'b0000 : err_q;
        mask_d   = maskBase;
        err_d    = errBase;
        dig_d    = dig_q;
        if (capture) begin
            mask_d[slotIdx] = 1'b1;
            err_d[slotIdx]  = decoded[4];
            dig_d[slotIdx]  = decoded[3:0];
        end
        done_d = capture && (mask_d == 4'b1111);
    end

    always_ff @(posedge sampleClk or posedge rst) begin
        if (rst) begin
            sample_q <= 11'h7FF;
            run_q    <= '0;
            idle_q   <= '0;
            dig_q    <= '0;
            mask_q   <= 4'b0000;
            err_q    <= 4'b0000;
            done_q   <= 1'b0;
            score_q  <= 14'd0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            sample_q <= newSample;
            run_q    <= run_d;
            idle_q   <= idle_d;
            dig_q    <= dig_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            done_q   <= done_d;
            score_q  <= score_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            stale_q  <= stale_d;
        end
    end

    assign score      = score_q;
    assign scoreValid = valid_q;
    assign frameErr   = ferr_q;
    assign stale      = stale_q;
    assign digitMask  = mask_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: behavioural frame model plus directed literal checks.
module tb_seg_scan_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 16;

    localparam logic [3:0] ONES = 4'b0111, TENS = 4'b1011, HUND = 4'b1101, THOU = 4'b1110, IDLE = 4'b1111;

    logic        sampleClk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  whichseg = 4'b1111;
    logic [6:0]  segval = 7'b1111111;
    logic [13:0] score;
    logic        scoreValid, frameErr, stale;
    logic [3:0]  digitMask;

    int checks = 0;
    int failures = 0;

    seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .sampleClk (sampleClk),
        .rst       (rst),
        .whichseg  (whichseg),
        .segval    (segval),
        .score     (score),
        .scoreValid(scoreValid),
        .frameErr  (frameErr),
        .stale     (stale),
        .digitMask (digitMask)
    );

    always #5 sampleClk = ~sampleClk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Holds one anode/segment pair for n sampling edges, returning just after a falling edge.
    task automatic applyStimulus(input logic [3:0] ws, input logic [6:0] sv, input int n);
        whichseg = ws;
        segval   = sv;
        repeat (n) @(negedge sampleClk);
        #1;
    endtask

    function automatic int slotOf(input logic [3:0] ws);
        case (ws)
            ONES:    return 0;
            TENS:    return 1;
            HUND:    return 2;
            THOU:    return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int digitOf(input logic [6:0] sv, input int slot);
        logic [6:0] table_[10];
        table_ = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                   7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        for (int i = 0; i < 10; i++)
            if (table_[i] == sv) return i;
`ifdef SEG_SCAN_BLANK_EN
        if (sv == 7'b1111111 && slot >= 2) return 0;
`endif
        if (slot < 0) return -1;
        return -1;
    endfunction

    // Behavioural model: streak of identical samples, captured digits, frame pending flag.
    logic [10:0] prevPair;
    int  streak, idleEdges, digits[4];
    logic [3:0] mask, bad;
    bit  pending;
    int  expScore, expValid, expErr, expStale;

    always @(posedge sampleClk or posedge rst) begin
        if (rst) begin
            prevPair = 11'h7FF; streak = 0; idleEdges = 0; mask = 0; bad = 0; pending = 0;
            for (int i = 0; i < 4; i++) digits[i] = 0;
            expScore = 0; expValid = 0; expErr = 0; expStale = 0;
        end else begin
            int slot, d;
            if ({whichseg, segval} == prevPair) streak++;
            else streak = 1;
            prevPair = {whichseg, segval};
            expValid = 0;
            expErr   = 0;
            if (pending) begin
                pending  = 0;
                expValid = 1;
                if (bad != 0) expErr = 1;
                else expScore = digits[3] * 1000 + digits[2] * 100 + digits[1] * 10 + digits[0];
                mask = 0;
                bad  = 0;
            end
            slot = slotOf(whichseg);
            if (streak == STABLE && slot >= 0) begin
                d = digitOf(segval, slot);
                idleEdges = 0;
                expStale  = 0;
                digits[slot] = (d < 0) ? 0 : d;
                bad[slot]    = (d < 0);
                mask[slot]   = 1'b1;
                if (mask == 4'b1111) pending = 1;
            end else begin
                idleEdges++;
                if (idleEdges == TIMEOUT) begin
                    expStale = 1;
                    mask = 0;
                    bad  = 0;
                end
            end
        end
    end

    int validCount = 0, errPulses = 0, lastScore = -1, lastErr = -1;

    always @(negedge sampleClk) begin
        if (!rst) begin
            checkOutput("cyc_score", int'(score), expScore);
            checkOutput("cyc_valid", int'(scoreValid), expValid);
            checkOutput("cyc_frameErr", int'(frameErr), expErr);
            checkOutput("cyc_stale", int'(stale), expStale);
            checkOutput("cyc_mask", int'(digitMask), int'(mask));
            if (scoreValid) begin
                validCount++;
                lastScore = int'(score);
                lastErr   = int'(frameErr);
            end
            if (frameErr) errPulses++;
        end
    end

    initial begin
        repeat (3) @(negedge sampleClk);
        #1;
        checkOutput("reset_score", int'(score), 0);
        checkOutput("reset_mask", int'(digitMask), 0);
        rst = 1'b0;

        applyStimulus(ONES, 7'b1001100, 8);
        applyStimulus(TENS, 7'b0000110, 8);
        applyStimulus(HUND, 7'b0010010, 8);
        applyStimulus(THOU, 7'b1001111, 8);
        checkOutput("f1234_count", validCount, 1);
        checkOutput("f1234_score", lastScore, 1234);
        checkOutput("f1234_err", lastErr, 0);

        applyStimulus(ONES, 7'b0010010, 8);
        applyStimulus(TENS, 7'b1111110, 8);
        applyStimulus(HUND, 7'b0000001, 8);
        applyStimulus(THOU, 7'b0000001, 8);
        checkOutput("f0042_count", validCount, 2);
        checkOutput("f0042_err", lastErr, 1);
        checkOutput("f0042_score", lastScore, 1234);

        applyStimulus(ONES, 7'b0000100, 8);
        checkOutput("f9999_mask1", int'(digitMask), 4'b0001);
        applyStimulus(TENS, 7'b0000100, 8);
        checkOutput("f9999_mask2", int'(digitMask), 4'b0011);
        applyStimulus(HUND, 7'b0000100, 8);
        checkOutput("f9999_mask3", int'(digitMask), 4'b0111);
        applyStimulus(THOU, 7'b0000100, 8);
        checkOutput("f9999_mask4", int'(digitMask), 4'b0000);
        checkOutput("f9999_score", lastScore, 9999);
        checkOutput("f9999_count", validCount, 3);

        applyStimulus(ONES, 7'b1001111, 8);
        applyStimulus(TENS, 7'b1001111, 8);
        applyStimulus(IDLE, 7'b1111111, 14);
        checkOutput("timeout_stale", int'(stale), 1);
        checkOutput("timeout_mask", int'(digitMask), 0);
        applyStimulus(ONES, 7'b0000001, 5);
        checkOutput("recap_stale", int'(stale), 0);
        checkOutput("recap_mask", int'(digitMask), 4'b0001);

        applyStimulus(IDLE, 7'b1111111, 100);
        checkOutput("idle_mask", int'(digitMask), 0);
        checkOutput("idle_stale", int'(stale), 1);
        checkOutput("idle_errs", errPulses, 1);
        applyStimulus(ONES, 7'b1001100, 3);
        applyStimulus(TENS, 7'b1001100, 3);
        applyStimulus(HUND, 7'b1001100, 3);
        checkOutput("short_mask", int'(digitMask), 0);
        checkOutput("short_stale", int'(stale), 1);

        applyStimulus(ONES, 7'b0100100, 8);
        applyStimulus(TENS, 7'b0100000, 8);
        applyStimulus(HUND, 7'b0000000, 8);
        checkOutput("partial_mask", int'(digitMask), 4'b0111);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_score", int'(score), 0);
        checkOutput("arst_valid", int'(scoreValid), 0);
        checkOutput("arst_err", int'(frameErr), 0);
        checkOutput("arst_stale", int'(stale), 0);
        checkOutput("arst_mask", int'(digitMask), 0);
        @(negedge sampleClk);
        #1 rst = 1'b0;
        whichseg = IDLE;
        segval   = 7'b1111111;

        applyStimulus(ONES, 7'b0001111, 8);
        applyStimulus(TENS, 7'b0000001, 8);
        applyStimulus(HUND, 7'b0000001, 8);
        applyStimulus(THOU, 7'b0000001, 8);
        checkOutput("f0007_count", validCount, 4);
        checkOutput("f0007_score", lastScore, 7);
        checkOutput("f0007_err", lastErr, 0);
        checkOutput("f0007_live", int'(score), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
